// File: rtl/pong_pkg.sv
// Shared definitions for the tile-map write path: default widths and the
// state encoding of the tile write queue controller.
package pong_pkg;

  localparam int TILE_ADDR_W = 5;
  localparam int TILE_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } tile_wq_state_t;

endpackage : pong_pkg

// File: rtl/tile_write_queue_fifo.sv
// Synchronous single-clock FIFO with first-word-fall-through read port.
// Push is ignored when full and pop is ignored when empty, so the caller
// can never corrupt the occupancy count.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array: write the pushed entry at the write pointer.
  // NOTE: the memory has no reset; its contents are only observable through
  // entries counted by r_count, so clearing it would cost logic for nothing.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/tile_write_queue.sv
// Tile write queue: buffers tile-map updates from game logic and commits
// them to the control-side RAM port only during vertical blank. A clear
// request fills every map cell with one tile code, then queued updates
// drain afterwards in FIFO order.
module tile_write_queue
  import pong_pkg::*;
#(
  parameter int ADDR_W = TILE_ADDR_W,
  parameter int DATA_W = TILE_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  input  logic [ADDR_W-1:0]        i_req_addr,
  input  logic [DATA_W-1:0]        i_req_data,
  output logic                     o_req_ready,
  input  logic                     i_vblank,
  input  logic                     i_clear,
  input  logic [DATA_W-1:0]        i_clear_tile,
  output logic [ADDR_W-1:0]        o_ram_address,
  output logic [DATA_W-1:0]        o_ram_data,
  output logic                     o_ram_wren,
  output logic [$clog2(DEPTH):0]   o_pending,
  output logic                     o_busy
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  tile_wq_state_t r_state;

  logic [ADDR_W-1:0]      r_ram_address;
  logic [DATA_W-1:0]      r_ram_data;
  logic                   r_ram_wren;
  logic [DATA_W-1:0]      r_clear_tile;
  logic [ADDR_W-1:0]      r_clear_cnt;

  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [ENTRY_W-1:0]     w_head;
  logic                   w_push;
  logic                   w_pop;

  // Readiness depends only on occupancy, never on the controller state.
  assign o_req_ready = !w_full;
  assign w_push      = i_req_valid && !w_full;

  // The head is popped from IDLE (unless a clear wins) or while draining,
  // but only when vblank is sampled high; a pending clear blocks the pop.
  assign w_pop = i_vblank && !w_empty &&
                 (((r_state == IDLE) && !i_clear) || (r_state == DRAIN));

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data ({i_req_addr, i_req_data}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Controller: selects between idle, vblank draining and full-map clear,
  // and registers the RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_clear_tile  <= '0;
      r_clear_cnt   <= '0;
    end else begin
      r_ram_wren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_clear) begin
            r_state      <= CLEAR;
            r_clear_tile <= i_clear_tile;
            r_clear_cnt  <= '0;
          end else if (w_pop) begin
            r_ram_address <= w_head[ENTRY_W-1:DATA_W];
            r_ram_data    <= w_head[DATA_W-1:0];
            r_ram_wren    <= 1'b1;
            r_state       <= DRAIN;
          end
        end
        DRAIN: begin
          // Clear requests arriving here are intentionally dropped.
          if (w_pop) begin
            r_ram_address <= w_head[ENTRY_W-1:DATA_W];
            r_ram_data    <= w_head[DATA_W-1:0];
            r_ram_wren    <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        CLEAR: begin
          // One cell per cycle regardless of vblank; further clears ignored.
          r_ram_address <= r_clear_cnt;
          r_ram_data    <= r_clear_tile;
          r_ram_wren    <= 1'b1;
          r_clear_cnt   <= r_clear_cnt + ADDR_W'(1);
          if (&r_clear_cnt) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ram_address = r_ram_address;
  assign o_ram_data    = r_ram_data;
  assign o_ram_wren    = r_ram_wren;
  assign o_pending     = w_count;
  assign o_busy        = (r_state == CLEAR) || (w_count != '0);

endmodule : tile_write_queue

// File: tb/tb_tile_write_queue.sv
// Self-checking bench for tile_write_queue. Every expected RAM write is
// queued on a scoreboard when the stimulus that causes it is applied; a
// negedge monitor pops and compares on each observed write strobe.
module tb_tile_write_queue;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready;
  logic       vblank;
  logic       clear;
  logic [7:0] clear_tile;
  logic [4:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [3:0] pending;
  logic       busy;

  int  vectors     = 0;
  int  miscompares = 0;
  int  wr_seen     = 0;
  wr_t sb[$];
  wr_t mon_exp;

  tile_write_queue #(
    .ADDR_W (5),
    .DATA_W (8),
    .DEPTH  (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_vblank      (vblank),
    .i_clear       (clear),
    .i_clear_tile  (clear_tile),
    .o_ram_address (ram_address),
    .o_ram_data    (ram_data),
    .o_ram_wren    (ram_wren),
    .o_pending     (pending),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && ram_wren) begin
      wr_seen++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%02h, required no write",
                 ram_address, ram_data);
      end else begin
        mon_exp = sb.pop_front();
        if (ram_address !== mon_exp.addr || ram_data !== mon_exp.data) begin
          miscompares++;
          $display("FAIL ram_write: got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                   ram_address, ram_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one update and hold it until accepted (bounded).
  task automatic push(input logic [4:0] a, input logic [7:0] d);
    bit accepted;
    accepted  = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    vectors++;
    if (!accepted) begin
      miscompares++;
      $display("FAIL push_timeout: got no acceptance, required acceptance of addr=%0d", a);
    end else begin
      sb.push_back('{addr: a, data: d});
    end
  endtask

  // Wait until every expected write has been observed and the block is quiet.
  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && (pending == 4'd0) && !busy && !ram_wren;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d writes outstanding pending=%0d, required 0 and 0",
               name, sb.size(), pending);
    end
    tick();
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_val("reset_ready", int'(req_ready), 1);
    check_val("reset_wren", int'(ram_wren), 0);
    check_val("reset_addr", int'(ram_address), 0);
    check_val("reset_data", int'(ram_data), 0);
    check_val("reset_pending", int'(pending), 0);
    check_val("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_queue_three();
    int  base;
    bit  seen;
    base   = wr_seen;
    vblank = 1'b0;
    push(5'd5, 8'h11);
    push(5'd6, 8'h22);
    push(5'd7, 8'h33);
    repeat (2) tick();
    check_val("q3_pending", int'(pending), 3);
    check_val("q3_no_write_outside_vblank", wr_seen - base, 0);
    vblank = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ram_wren;
    end
    check_val("q3_first_write", int'(seen), 1);
    @(negedge clk);
    check_val("q3_second_consecutive", int'(ram_wren), 1);
    @(negedge clk);
    check_val("q3_third_consecutive", int'(ram_wren), 1);
    wait_drain(20, "q3");
    check_val("q3_write_count", wr_seen - base, 3);
    check_val("q3_pending_after", int'(pending), 0);
    vblank = 1'b0;
  endtask

  task automatic test_full();
    int base;
    base   = wr_seen;
    vblank = 1'b0;
    for (int i = 0; i < 8; i++) push(5'(i + 16), 8'(8'h40 + i));
    check_val("full_ready_low", int'(req_ready), 0);
    check_val("full_pending", int'(pending), 8);
    req_valid = 1'b1;
    req_addr  = 5'd30;
    req_data  = 8'hE9;
    repeat (3) tick();
    check_val("full_ninth_held_pending", int'(pending), 8);
    check_val("full_ninth_held_ready", int'(req_ready), 0);
    vblank = 1'b1;
    push(5'd30, 8'hE9);
    wait_drain(40, "full");
    check_val("full_write_count", wr_seen - base, 9);
    vblank = 1'b0;
  endtask

  task automatic test_clear();
    wr_t held[$];
    int  base;
    base   = wr_seen;
    vblank = 1'b0;
    push(5'd1, 8'hA1);
    push(5'd2, 8'hB2);
    held = sb;
    sb.delete();
    for (int c = 0; c < 32; c++) sb.push_back('{addr: 5'(c), data: 8'h00});
    foreach (held[i]) sb.push_back(held[i]);
    vblank     = 1'b1;
    clear      = 1'b1;
    clear_tile = 8'h00;
    tick();
    clear = 1'b0;
    check_val("clear_busy", int'(busy), 1);
    repeat (5) tick();
    clear      = 1'b1;
    clear_tile = 8'h55;
    tick();
    clear = 1'b0;
    wait_drain(100, "clear");
    check_val("clear_write_count", wr_seen - base, 34);
    // Second fill with vblank low: clear writes ignore vblank.
    base   = wr_seen;
    vblank = 1'b0;
    for (int c = 0; c < 32; c++) sb.push_back('{addr: 5'(c), data: 8'h3C});
    clear      = 1'b1;
    clear_tile = 8'h3C;
    tick();
    clear = 1'b0;
    wait_drain(60, "clear_novblank");
    check_val("clear_novblank_count", wr_seen - base, 32);
  endtask

  task automatic test_vblank_fall();
    int base;
    base   = wr_seen;
    vblank = 1'b0;
    push(5'd9,  8'h91);
    push(5'd10, 8'hA2);
    push(5'd11, 8'hB3);
    push(5'd12, 8'hC4);
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    repeat (4) tick();
    check_val("vfall_writes", wr_seen - base, 2);
    check_val("vfall_pending", int'(pending), 2);
    vblank = 1'b1;
    wait_drain(20, "vfall");
    check_val("vfall_resume_writes", wr_seen - base, 4);
    vblank = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    wr_t held[$];
    int  base;
    bit  found;
    vblank = 1'b0;
    push(5'd3, 8'h33);
    push(5'd4, 8'h44);
    held = sb;
    sb.delete();
    for (int c = 0; c < 32; c++) sb.push_back('{addr: 5'(c), data: 8'h77});
    foreach (held[i]) sb.push_back(held[i]);
    clear      = 1'b1;
    clear_tile = 8'h77;
    tick();
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = ram_wren && (ram_address == 5'd10);
    end
    check_val("rstclr_reached_cell10", int'(found), 1);
    rst = 1'b1;
    sb.delete();
    base = wr_seen;
    tick();
    check_val("rstclr_wren", int'(ram_wren), 0);
    check_val("rstclr_pending", int'(pending), 0);
    check_val("rstclr_busy", int'(busy), 0);
    check_val("rstclr_ready", int'(req_ready), 1);
    rst    = 1'b0;
    vblank = 1'b1;
    repeat (6) tick();
    check_val("rstclr_no_writes_after", wr_seen - base, 0);
    vblank = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    base   = wr_seen;
    vblank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(5'(i), 8'(i * 7 + 1));
      check_val("b2b_pending_const", int'(pending), 1);
    end
    wait_drain(20, "b2b");
    check_val("b2b_write_count", wr_seen - base, 20);
    vblank = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    vblank     = 1'b0;
    clear      = 1'b0;
    clear_tile = '0;
    #1;
    test_reset();
    test_queue_three();
    test_full();
    test_clear();
    test_vblank_fall();
    test_reset_mid_clear();
    test_back_to_back();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tile_write_queue
